// File: rtl/ghash_pkg.sv
// rtl/ghash_pkg.sv - shared GHASH constants, FSM encodings and configuration check
package ghash_pkg;

    localparam int           NB_BLOCK_GCM = 128;
    localparam logic [127:0] GCM_R_POLY   = {8'hE1, 120'h0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Digit width must be a power of two that divides the 128-bit block.
    function automatic bit bad_conf(input int nb_block, input int n_blocks, input int nb_digit);
        return (nb_block != NB_BLOCK_GCM) || (n_blocks < 1) || (nb_digit < 1) ||
               (nb_digit > NB_BLOCK_GCM) || ((NB_BLOCK_GCM % nb_digit) != 0);
    endfunction

endpackage

// File: rtl/ghash_digit_mult_step.sv
// rtl/ghash_digit_mult_step.sv - NB_DIGIT unrolled bit steps of the GCM right-shift multiplier
module ghash_digit_mult_step
    import ghash_pkg::*;
#(
    parameter int NB_DIGIT = 8
)(
    input  logic [127:0]          i_z,
    input  logic [127:0]          i_v,
    input  logic [NB_DIGIT-1:0]   i_x_digit,
    output logic [127:0]          o_z,
    output logic [127:0]          o_v
);

    logic [127:0] w_z;
    logic [127:0] w_v;

    // Digit MSB is the earliest multiplier bit (lowest-degree coefficient first).
    always_comb begin
        w_z = i_z;
        w_v = i_v;
        for (int i = NB_DIGIT - 1; i >= 0; i--) begin
            if (i_x_digit[i]) begin
                w_z = w_z ^ w_v;
            end
            w_v = {1'b0, w_v[127:1]} ^ (w_v[0] ? GCM_R_POLY : 128'h0);
        end
    end

    assign o_z = w_z;
    assign o_v = w_v;

endmodule

// File: rtl/ghash_h_powers_gen.sv
// rtl/ghash_h_powers_gen.sv - computes H^1..H^N with one digit-serial GF(2^128) multiplier
module ghash_h_powers_gen
    import ghash_pkg::*;
#(
    parameter int NB_BLOCK = 128,
    parameter int N_BLOCKS = 2,
    parameter int NB_DATA  = N_BLOCKS * NB_BLOCK,
    parameter int NB_DIGIT = 8
)(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BLOCK-1:0] i_h_key,
    input  logic                i_load,
    output logic [NB_DATA-1:0]  o_h_key_powers,
    output logic                o_ready,
    output logic                o_busy
);

    localparam bit BAD_CONF = bad_conf(NB_BLOCK, N_BLOCKS, NB_DIGIT);
    localparam int CYC      = NB_BLOCK_GCM / NB_DIGIT;
    localparam int NB_DCNT  = $clog2(CYC) + 1;
    localparam int NB_PIDX  = $clog2(N_BLOCKS) + 1;

    state_t               r_state;
    logic [127:0]         r_key;
    logic [127:0]         r_z;
    logic [127:0]         r_v;
    logic [127:0]         r_x;
    logic [NB_DCNT-1:0]   r_dcnt;
    logic [NB_PIDX-1:0]   r_pidx;
    logic [NB_DATA-1:0]   r_powers;
    logic                 r_ready;
    logic                 r_busy;

    logic [127:0]         w_z_next;
    logic [127:0]         w_v_next;
    logic [NB_DIGIT-1:0]  w_x_digit;

    assign w_x_digit = r_x[127 -: NB_DIGIT];

    ghash_digit_mult_step #(
        .NB_DIGIT (NB_DIGIT)
    ) u_step (
        .i_z       (r_z),
        .i_v       (r_v),
        .i_x_digit (w_x_digit),
        .o_z       (w_z_next),
        .o_v       (w_v_next)
    );

    // A bad configuration keeps the block parked in IDLE with all outputs low.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_key    <= '0;
            r_z      <= '0;
            r_v      <= '0;
            r_x      <= '0;
            r_dcnt   <= '0;
            r_pidx   <= '0;
            r_powers <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_load && !BAD_CONF) begin
            r_state  <= ST_LOAD;
            r_key    <= 128'(i_h_key);
            r_dcnt   <= '0;
            r_pidx   <= '0;
            r_powers <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_powers[0 +: NB_BLOCK] <= NB_BLOCK'(r_key);
                    r_z    <= '0;
                    r_v    <= r_key;
                    r_x    <= r_key;
                    r_dcnt <= '0;
                    r_pidx <= NB_PIDX'(1);
                    if (N_BLOCKS > 1) begin
                        r_state <= ST_MULT;
                    end else begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (r_dcnt == NB_DCNT'(CYC - 1)) begin
                        for (int k = 1; k < N_BLOCKS; k++) begin
                            if (r_pidx == NB_PIDX'(k)) begin
                                r_powers[k*NB_BLOCK +: NB_BLOCK] <= NB_BLOCK'(w_z_next);
                            end
                        end
                        // Next power reuses the product just formed as its multiplier.
                        if (r_pidx < NB_PIDX'(N_BLOCKS - 1)) begin
                            r_z    <= '0;
                            r_v    <= r_key;
                            r_x    <= w_z_next;
                            r_dcnt <= '0;
                            r_pidx <= r_pidx + 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_z    <= w_z_next;
                        r_v    <= w_v_next;
                        r_x    <= r_x << NB_DIGIT;
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_h_key_powers = r_powers;
    assign o_ready        = r_ready;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_ghash_h_powers_gen.sv
// tb/tb_ghash_h_powers_gen.sv - randomized self-checking bench for ghash_h_powers_gen
module tb_ghash_h_powers_gen;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [127:0]   key;
    logic [511:0]   pw4;
    logic [255:0]   pw2;
    logic [127:0]   pw1;
    logic [1023:0]  pw8;
    logic [3:0]     rdy;
    logic [3:0]     bsy;
    logic [1023:0]  pad [4];

    int total = 0;
    int bad   = 0;
    int first  [4];
    int hazard [4];
    int nbk    [4] = '{4, 2, 1, 8};
    int ndig   [4] = '{8, 8, 128, 1};

    always #5 clk = ~clk;

    ghash_h_powers_gen #(.NB_BLOCK(128), .N_BLOCKS(4), .NB_DIGIT(8)) u_n4 (
        .i_clock(clk), .i_reset(rst), .i_h_key(key), .i_load(load),
        .o_h_key_powers(pw4), .o_ready(rdy[0]), .o_busy(bsy[0]));
    ghash_h_powers_gen #(.NB_BLOCK(128), .N_BLOCKS(2), .NB_DIGIT(8)) u_n2 (
        .i_clock(clk), .i_reset(rst), .i_h_key(key), .i_load(load),
        .o_h_key_powers(pw2), .o_ready(rdy[1]), .o_busy(bsy[1]));
    ghash_h_powers_gen #(.NB_BLOCK(128), .N_BLOCKS(1), .NB_DIGIT(128)) u_n1 (
        .i_clock(clk), .i_reset(rst), .i_h_key(key), .i_load(load),
        .o_h_key_powers(pw1), .o_ready(rdy[2]), .o_busy(bsy[2]));
    ghash_h_powers_gen #(.NB_BLOCK(128), .N_BLOCKS(8), .NB_DIGIT(1)) u_n8 (
        .i_clock(clk), .i_reset(rst), .i_h_key(key), .i_load(load),
        .o_h_key_powers(pw8), .o_ready(rdy[3]), .o_busy(bsy[3]));

    assign pad[0] = {512'b0, pw4};
    assign pad[1] = {768'b0, pw2};
    assign pad[2] = {896'b0, pw1};
    assign pad[3] = pw8;

    // Reference: polynomial carry-less product, then reduction by x^128+x^7+x^2+x+1.
    function automatic logic [127:0] rev128(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] p;
        logic [254:0] m;
        logic [127:0] ra;
        logic [127:0] rb;
        ra = rev128(a);
        rb = rev128(b);
        p  = '0;
        m  = {126'b0, 1'b1, 120'b0, 8'h87};
        for (int i = 0; i < 128; i++) if (ra[i]) p = p ^ (255'(rb) << i);
        for (int i = 254; i >= 128; i--) if (p[i]) p = p ^ (m << (i - 128));
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] model_pow(input logic [127:0] h, input int k);
        logic [127:0] p;
        p = h;
        for (int i = 0; i < k; i++) p = gf_mul(p, h);
        return p;
    endfunction

    function automatic int exp_lat(input int j);
        return 1 + (nbk[j] - 1) * (128 / ndig[j]);
    endfunction

    task automatic pulse_load(input logic [127:0] h);
        key  = h;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic observe(input int maxc);
        for (int j = 0; j < 4; j++) begin
            first[j]  = -1;
            hazard[j] = 0;
        end
        for (int c = 0; c <= maxc; c++) begin
            if (c > 0) @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (rdy[j] === 1'b1 && first[j] < 0) first[j] = c;
                if (first[j] >= 0 && rdy[j] !== 1'b1) hazard[j]++;
                if (rdy[j] === bsy[j]) hazard[j]++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; key = '0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (pad[j] !== '0 || rdy[j] !== 1'b0 || bsy[j] !== 1'b0) begin
                bad++;
                $display("FAIL reset inst=%0d rdy=%b bsy=%b pw_nonzero=%b expected all 0",
                         j, rdy[j], bsy[j], pad[j] != '0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [127:0] keys [3];
        logic [511:0] c4   [2];
        keys[0] = {8'h80, 120'h0};
        keys[1] = {8'h40, 120'h0};
        keys[2] = 128'h1;
        c4[0]   = {4{keys[0]}};
        c4[1]   = {8'h08, 120'h0, 8'h10, 120'h0, 8'h20, 120'h0, 8'h40, 120'h0};
        for (int t = 0; t < 3; t++) begin
            pulse_load(keys[t]);
            observe(900);
            for (int j = 0; j < 4; j++) begin
                total++;
                if (first[j] != exp_lat(j) || hazard[j] != 0) begin
                    bad++;
                    $display("FAIL directed_lat key=%0d inst=%0d got=%0d hazards=%0d exp=%0d",
                             t, j, first[j], hazard[j], exp_lat(j));
                end
                for (int k = 0; k < nbk[j]; k++) begin
                    total++;
                    if (pad[j][k*128 +: 128] !== model_pow(keys[t], k)) begin
                        bad++;
                        $display("FAIL directed_slot key=%0d inst=%0d slot=%0d got=%h exp=%h",
                                 t, j, k, pad[j][k*128 +: 128], model_pow(keys[t], k));
                    end
                end
            end
            if (t < 2) begin
                total++;
                if (pw4 !== c4[t]) begin
                    bad++;
                    $display("FAIL directed_const key=%0d got=%h exp=%h", t, pw4, c4[t]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [127:0] h;
        for (int t = 0; t < 25; t++) begin
            h = {$urandom, $urandom, $urandom, $urandom};
            pulse_load(h);
            observe(900);
            for (int j = 0; j < 4; j++) begin
                total++;
                if (first[j] != exp_lat(j) || hazard[j] != 0) begin
                    bad++;
                    $display("FAIL random_lat iter=%0d inst=%0d got=%0d hazards=%0d exp=%0d",
                             t, j, first[j], hazard[j], exp_lat(j));
                end
                for (int k = 0; k < nbk[j]; k++) begin
                    total++;
                    if (pad[j][k*128 +: 128] !== model_pow(h, k)) begin
                        bad++;
                        $display("FAIL random_slot iter=%0d inst=%0d slot=%0d got=%h exp=%h",
                                 t, j, k, pad[j][k*128 +: 128], model_pow(h, k));
                    end
                end
            end
        end
    endtask

    task automatic restart_after(input string name, input int gap);
        logic [127:0] ha;
        logic [127:0] hb;
        int           early;
        ha    = {$urandom, $urandom, $urandom, $urandom};
        hb    = {$urandom, $urandom, $urandom, $urandom};
        early = 0;
        pulse_load(ha);
        for (int c = 1; c < gap; c++) begin
            @(negedge clk);
            // Only instances whose latency exceeds the gap must still be not ready.
            for (int j = 0; j < 4; j++) if (exp_lat(j) > c && rdy[j] !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL %s_early_ready got=%0d exp=0", name, early);
        end
        pulse_load(hb);
        observe(900);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (first[j] != exp_lat(j) || hazard[j] != 0) begin
                bad++;
                $display("FAIL %s_lat inst=%0d got=%0d hazards=%0d exp=%0d",
                         name, j, first[j], hazard[j], exp_lat(j));
            end
            for (int k = 0; k < nbk[j]; k++) begin
                total++;
                if (pad[j][k*128 +: 128] !== model_pow(hb, k)) begin
                    bad++;
                    $display("FAIL %s_slot inst=%0d slot=%0d got=%h exp=%h",
                             name, j, k, pad[j][k*128 +: 128], model_pow(hb, k));
                end
            end
        end
    endtask

    task automatic test_restart;
        restart_after("restart", 5);
    endtask

    task automatic test_back_to_back;
        restart_after("back_to_back", 20);
    endtask

    task automatic test_reset_abort(input string name, input bit same_edge);
        int seen;
        if (same_edge) begin
            rst = 1'b1;
            key = {$urandom, $urandom, $urandom, $urandom};
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
        end else begin
            pulse_load({$urandom, $urandom, $urandom, $urandom});
            repeat (9) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (pad[j] !== '0 || rdy[j] !== 1'b0 || bsy[j] !== 1'b0) begin
                bad++;
                $display("FAIL %s_zero inst=%0d rdy=%b bsy=%b pw_nonzero=%b expected all 0",
                         name, j, rdy[j], bsy[j], pad[j] != '0);
            end
        end
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 950; c++) begin
            @(negedge clk);
            if (rdy !== 4'b0 || bsy !== 4'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s_idle active_cycles got=%0d exp=0", name, seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_back_to_back();
        test_reset_abort("reset_mid", 1'b0);
        test_reset_abort("reset_with_load", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
